// File: rtl/pump_arb_pkg.sv
// Shared types and defaults for the pump round-robin arbiter.
// The clog2 helper never returns less than 1 so counters and indices keep a real bit.
package pump_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GUARD = 2'b10
  } arb_state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_MIN_ON = 4;
  localparam int DEF_MAX_ON = 16;
  localparam int DEF_GAP    = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first asserted request at ptr, ptr+1, ...
// wrapping modulo N_REQ. Purely combinational.
module rr_pick
  import pump_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o
);

  localparam logic [IW:0] N_W = (IW + 1)'(N_REQ);

  logic [IW-1:0]    pos [N_REQ];
  logic [N_REQ-1:0] hit;

  // pos[gi] is the channel examined at rotation offset gi from the pointer
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum     = {1'b0, ptr_i} + (IW + 1)'(gi);
    assign pos[gi] = (sum >= N_W) ? IW'(sum - N_W) : IW'(sum);
    assign hit[gi] = req_i[pos[gi]];
  end

  // Scan from the far end so the smallest offset with a hit wins
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid_o = 1'b1;
        idx_o   = pos[i];
      end
    end
  end

endmodule

// File: rtl/pump_rr_arbiter.sv
// Round-robin arbiter sharing one pump/valve among N_REQ channels, with minimum
// on-time, maximum on-time cut-off and a guard gap after every release.
module pump_rr_arbiter
  import pump_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int MIN_ON = DEF_MIN_ON,
  parameter int MAX_ON = DEF_MAX_ON,
  parameter int GAP    = DEF_GAP
) (
  input  logic                      inputClk,
  input  logic                      inputReset,
  input  logic                      inputEnable,
  input  logic [N_REQ-1:0]          inputReq,
  output logic [N_REQ-1:0]          outputGrant,
  output logic [clog2(N_REQ)-1:0]   outputGrantId,
  output logic                      outputBusy,
  output logic                      outputOverrun
);

  localparam int IW = clog2(N_REQ);
  localparam int OW = clog2(MAX_ON + 1);
  localparam int GW = clog2(GAP + 1);

  localparam logic [OW-1:0] ON_SAT   = OW'(MAX_ON);
  localparam logic [OW-1:0] ON_LAST  = OW'(MAX_ON - 1);
  localparam logic [OW-1:0] MIN_LAST = OW'(MIN_ON - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [IW-1:0] ID_LAST  = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    id_q, id_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    on_q, on_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i   (inputReq),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    id_d        = id_q;
    busy_d      = busy_q;
    ovr_d       = 1'b0;
    ptr_d       = ptr_q;
    on_d        = on_q;
    gap_d       = gap_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (inputEnable && pick_valid) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          id_d              = pick_idx;
          busy_d            = 1'b1;
          on_d              = '0;
        end
      end

      GRANT: begin
        on_d = (on_q == ON_SAT) ? on_q : on_q + OW'(1);
        // Release priority: enable drop, then overrun, then request drop past MIN_ON
        if (!inputEnable) begin
          release_now = 1'b1;
        end else if (on_q == ON_LAST) begin
          release_now = 1'b1;
          ovr_d       = 1'b1;
        end else if ((on_q >= MIN_LAST) && !inputReq[id_q]) begin
          release_now = 1'b1;
        end

        if (release_now) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (id_q == ID_LAST) ? '0 : id_q + IW'(1);
          gap_d   = '0;
          state_d = (GAP == 0) ? IDLE : GUARD;
        end
      end

      GUARD: begin
        if (gap_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ptr_q   <= '0;
      on_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
      on_q    <= on_d;
      gap_q   <= gap_d;
    end
  end

  assign outputGrant   = grant_q;
  assign outputGrantId = id_q;
  assign outputBusy    = busy_q;
  assign outputOverrun = ovr_q;

endmodule
